// File: rtl/ring_rotate_pkg.sv
// Shared types and constants for the ring rotate sequencer.
//   state_t         : controller states (IDLE, ROTATE, DONE)
//   WIDTH_DEF       : default ring width
//   STEP_WIDTH_DEF  : default step-count field width
//   DIR_RIGHT/LEFT  : encodings of the direction input
package ring_rotate_pkg;

    localparam int WIDTH_DEF      = 5;
    localparam int STEP_WIDTH_DEF = 6;

    // Right: out[0]<=out[W-1], out[i]<=out[i-1].
    // Left:  out[W-1]<=out[0], out[i]<=out[i+1].
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/ring_rotate_sequencer_if.sv
// Command/status bundle for the ring rotate sequencer.
//   master : command side (start, pattern, steps, direction, hold in;
//            out, notout, busy, done, error observed)
//   slave  : sequencer side (the inverse directions)
interface ring_rotate_sequencer_if #(
    parameter int WIDTH      = 5,
    parameter int STEP_WIDTH = 6
);
    logic                  start;
    logic [WIDTH-1:0]      pattern;
    logic [STEP_WIDTH-1:0] steps;
    logic                  direction;
    logic                  hold;
    logic [WIDTH-1:0]      out;
    logic [WIDTH-1:0]      notout;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        output start, pattern, steps, direction, hold,
        input  out, notout, busy, done, error
    );

    modport slave (
        input  start, pattern, steps, direction, hold,
        output out, notout, busy, done, error
    );
endinterface

// File: rtl/ring_rotate_datapath.sv
// WIDTH-bit circular shift register.
//   clockpulse/clear : clock, async active-low reset (ring cleared to 0)
//   load, load_val   : parallel load (takes priority over rotation)
//   rot_en, dir      : rotate one position in direction dir this edge
//   out, notout      : register contents and their complement
module ring_rotate_datapath
    import ring_rotate_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             rot_en,
    input  logic             dir,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] notout
);
    logic [WIDTH-1:0] ring;

    always_ff @(posedge clockpulse or negedge clear) begin
        if (!clear) begin
            ring <= '0;
        end else if (load) begin
            ring <= load_val;
        end else if (rot_en) begin
            if (dir == DIR_LEFT) ring <= {ring[0], ring[WIDTH-1:1]};
            else                 ring <= {ring[WIDTH-2:0], ring[WIDTH-1]};
        end
    end

    assign out    = ring;
    // Complement follows the register directly, so it is valid in reset too.
    assign notout = ~ring;
endmodule

// File: rtl/ring_rotate_sequencer.sv
// Controller for the circular shift register: accepts a start command in
// IDLE, loads the pattern, rotates it the commanded number of steps and
// pulses done (with error if the pattern was all zeros).
//   clockpulse : system clock, rising edge
//   clear      : async active-low reset; aborts any command without done
//   bus        : command/status interface (slave side)
module ring_rotate_sequencer
    import ring_rotate_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int STEP_WIDTH = STEP_WIDTH_DEF
) (
    input  logic                     clockpulse,
    input  logic                     clear,
    ring_rotate_sequencer_if.slave   bus
);
    state_t                state, state_nxt;
    logic [STEP_WIDTH-1:0] cnt, cnt_nxt;
    logic                  dir_q, dir_nxt;
    logic                  err_nxt;
    logic                  load, rot_en;
    logic                  busy_q, done_q, err_q;
    logic [WIDTH-1:0]      ring_out, ring_notout;

    always_ff @(posedge clockpulse or negedge clear) begin
        if (!clear) begin
            state  <= IDLE;
            cnt    <= '0;
            dir_q  <= DIR_RIGHT;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            dir_q  <= dir_nxt;
            // Status flags are registered from the next state so they line
            // up with the state they describe without an output decode.
            busy_q <= (state_nxt != IDLE);
            done_q <= (state_nxt == DONE);
            err_q  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dir_nxt   = dir_q;
        err_nxt   = 1'b0;
        load      = 1'b0;
        rot_en    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    cnt_nxt = bus.steps;
                    dir_nxt = bus.direction;
                    if (bus.pattern == '0) begin
                        // An all-zero ring can never show movement: reject.
                        state_nxt = DONE;
                        err_nxt   = 1'b1;
                    end else begin
                        load      = 1'b1;
                        state_nxt = (bus.steps == '0) ? DONE : ROTATE;
                    end
                end
            end
            ROTATE: begin
                if (!bus.hold) begin
                    rot_en  = 1'b1;
                    cnt_nxt = cnt - STEP_WIDTH'(1);
                    // The edge doing the final rotation also enters DONE.
                    if (cnt == STEP_WIDTH'(1)) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    ring_rotate_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clockpulse (clockpulse),
        .clear      (clear),
        .load       (load),
        .load_val   (bus.pattern),
        .rot_en     (rot_en),
        .dir        (dir_q),
        .out        (ring_out),
        .notout     (ring_notout)
    );

    assign bus.out    = ring_out;
    assign bus.notout = ring_notout;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.error  = err_q;
endmodule

// File: tb/tb_ring_rotate_sequencer.sv
module tb_ring_rotate_sequencer;
    localparam int W  = 5;
    localparam int SW = 6;

    logic clk;
    logic clear;
    int   vectors = 0;
    int   miss    = 0;
    bit   chk_en  = 0;

    ring_rotate_sequencer_if #(.WIDTH(W), .STEP_WIDTH(SW)) bus ();

    ring_rotate_sequencer #(.WIDTH(W), .STEP_WIDTH(SW)) dut (
        .clockpulse (clk),
        .clear      (clear),
        .bus        (bus)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Tracks a command as "base pattern + number of rotations performed";
    // the expected ring is computed arithmetically from those.
    int m_out = 0, m_busy = 0, m_done = 0, m_err = 0;
    int m_base = 0, m_j = 0, m_rem = 0, m_dir = 0, m_fin = 0;

    function automatic int rotn(input int b, input int j, input int d);
        int s;
        s = j % W;
        if (s == 0) return b;
        if (d == 0) return ((b << s) | (b >> (W - s))) & 31;
        return ((b >> s) | (b << (W - s))) & 31;
    endfunction

    always @(posedge clk or negedge clear) begin
        if (!clear) begin
            m_out = 0; m_busy = 0; m_done = 0; m_err = 0;
            m_fin = 0; m_rem = 0; m_j = 0;
        end else begin
            m_done = 0;
            m_err  = 0;
            if (m_fin != 0) begin
                m_fin  = 0;
                m_busy = 0;
            end else if (m_busy == 0) begin
                if (bus.start) begin
                    m_busy = 1;
                    if (bus.pattern == 0) begin
                        m_fin = 1; m_done = 1; m_err = 1;
                    end else begin
                        m_base = int'(bus.pattern);
                        m_j    = 0;
                        m_rem  = int'(bus.steps);
                        m_dir  = int'(bus.direction);
                        m_out  = m_base;
                        if (m_rem == 0) begin m_fin = 1; m_done = 1; end
                    end
                end
            end else if (!bus.hold) begin
                m_j   = m_j + 1;
                m_rem = m_rem - 1;
                m_out = rotn(m_base, m_j, m_dir);
                if (m_rem == 0) begin m_fin = 1; m_done = 1; end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (int'(bus.out) != m_out || int'(bus.notout) != (~m_out & 31) ||
                int'(bus.busy) != m_busy || int'(bus.done) != m_done ||
                int'(bus.error) != m_err) begin
                miss++;
                $display("FAIL model t=%0t out=%b/%b notout=%b busy=%0d/%0d done=%0d/%0d err=%0d/%0d (actual/required)",
                         $time, bus.out, m_out[W-1:0], bus.notout, bus.busy, m_busy,
                         bus.done, m_done, bus.error, m_err);
            end
        end
    end

    // ---------------- directed checks ----------------
    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // Start is applied for one edge; inputs are then scrambled to show
    // the command was captured.
    task automatic issue(input logic [W-1:0] p, input int s, input logic d);
        bus.start = 1; bus.pattern = p; bus.steps = SW'(s); bus.direction = d;
        cyc();
        bus.start = 0; bus.pattern = 5'b10101; bus.steps = 6'd9; bus.direction = ~d;
    endtask

    initial begin
        int n;
        bus.start = 0; bus.pattern = 0; bus.steps = 0; bus.direction = 0; bus.hold = 0;
        clear = 1;
        #3 clear = 0;
        #1;
        chk("rst_out", int'(bus.out), 0);
        chk("rst_notout", int'(bus.notout), 5'b11111);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err", int'(bus.error), 0);
        @(negedge clk); chk_en = 1;
        @(negedge clk); clear = 1;
        cyc();

        // right rotate 3 steps
        issue(5'b00001, 3, 0);
        chk("r3_load", int'(bus.out), 5'b00001);
        chk("r3_busy", int'(bus.busy), 1);
        cyc(); chk("r3_s1", int'(bus.out), 5'b00010);
        cyc(); chk("r3_s2", int'(bus.out), 5'b00100);
        cyc(); chk("r3_s3", int'(bus.out), 5'b01000);
        chk("r3_done", int'(bus.done), 1);
        cyc(); chk("r3_idle", int'(bus.busy), 0);
        chk("r3_hold_out", int'(bus.out), 5'b01000);
        cyc();

        // left rotate 2 steps
        issue(5'b10011, 2, 1);
        chk("l2_load", int'(bus.out), 5'b10011);
        cyc(); chk("l2_s1", int'(bus.out), 5'b11001);
        cyc(); chk("l2_s2", int'(bus.out), 5'b11100);
        chk("l2_done", int'(bus.done), 1);
        chk("l2_err", int'(bus.error), 0);
        cyc(); cyc();

        // zero steps
        issue(5'b00101, 0, 0);
        chk("z_out", int'(bus.out), 5'b00101);
        chk("z_done", int'(bus.done), 1);
        cyc(); chk("z_out_after", int'(bus.out), 5'b00101);
        chk("z_idle", int'(bus.busy), 0);

        // rejected all-zero pattern
        issue(5'b00000, 5, 0);
        chk("rej_out", int'(bus.out), 5'b00101);
        chk("rej_done", int'(bus.done), 1);
        chk("rej_err", int'(bus.error), 1);
        cyc(); chk("rej_done_off", int'(bus.done), 0);
        chk("rej_idle", int'(bus.busy), 0);
        cyc();

        // 4 steps with a 2-cycle hold: done 6 edges after accept, out 10000
        issue(5'b00001, 4, 0);
        cyc(); chk("h_s1", int'(bus.out), 5'b00010);
        bus.hold = 1;
        cyc(); chk("h_frz1", int'(bus.out), 5'b00010);
        cyc(); chk("h_frz2", int'(bus.out), 5'b00010);
        bus.hold = 0;
        n = 3;
        while (!bus.done && n < 20) begin cyc(); n++; end
        chk("h_done_lat", n, 6);
        chk("h_final", int'(bus.out), 5'b10000);
        cyc(); cyc();

        // back-to-back: start held high through the first command
        bus.start = 1; bus.pattern = 5'b00011; bus.steps = 6'd1; bus.direction = 0;
        cyc(); chk("bb_load", int'(bus.out), 5'b00011);
        bus.pattern = 5'b01000;
        cyc(); chk("bb_done", int'(bus.done), 1);
        chk("bb_s1", int'(bus.out), 5'b00110);
        cyc(); chk("bb_idle", int'(bus.busy), 0);
        cyc(); chk("bb_second", int'(bus.out), 5'b01000);
        chk("bb_busy2", int'(bus.busy), 1);
        bus.start = 0;
        cyc(); cyc(); cyc();

        // reset mid-rotation
        issue(5'b00001, 10, 0);
        cyc(); cyc();
        clear = 0;
        #2;
        chk("ar_out", int'(bus.out), 0);
        chk("ar_notout", int'(bus.notout), 5'b11111);
        chk("ar_busy", int'(bus.busy), 0);
        chk("ar_done", int'(bus.done), 0);
        @(negedge clk); #1 clear = 1;
        cyc();
        chk("ar_no_done", int'(bus.done), 0);
        issue(5'b00110, 1, 1);
        chk("ar_restart", int'(bus.out), 5'b00110);
        cyc(); chk("ar_rot", int'(bus.out), 5'b00011);
        chk("ar_rdone", int'(bus.done), 1);
        cyc(); cyc();

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end
endmodule
